// File: rtl/fe_capture_sequencer.sv
// fe_capture_sequencer: arm -> flush -> trigger delay -> capture window sequencer for the front-end capture path.
// Optional FE_SEQ_MULTI_TRIG_EN: several trigger windows per arm (otherwise exactly one).
module fe_capture_sequencer #(
    parameter int pDELAY_WIDTH      = 20,
    parameter int pWINDOW_WIDTH     = 20,
    parameter int pTRIG_COUNT_WIDTH = 8
) (
    input  logic                         fe_clk,
    input  logic                         reset_n,
    input  logic                         I_arm,
    input  logic                         I_abort,
    input  logic                         I_trigger,
    input  logic [pDELAY_WIDTH-1:0]      I_trig_delay,
    input  logic [pWINDOW_WIDTH-1:0]     I_window_len,
    input  logic [pTRIG_COUNT_WIDTH-1:0] I_num_triggers,
    input  logic                         I_fifo_empty,
    input  logic                         I_capturing,
    output logic                         O_flush,
    output logic                         O_capture_enable,
    output logic                         O_armed,
    output logic                         O_done,
    output logic [pTRIG_COUNT_WIDTH-1:0] O_trig_count,
    output logic [2:0]                   O_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        ARMED   = 3'd2,
        DELAY   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                       state;
    logic                         arm_r, trig_r, primed, seen_capturing;
    logic [pDELAY_WIDTH-1:0]      delay_cnt;
    logic [pWINDOW_WIDTH-1:0]     win_cnt, win_len;
    logic [pTRIG_COUNT_WIDTH-1:0] next_count;
    logic                         arm_edge, trig_edge, abort_act, start, win_end, last_window;

    // Edges are ignored on the first clock after reset so a held-high input cannot fire.
    assign arm_edge   = primed & I_arm & ~arm_r;
    assign trig_edge  = primed & I_trigger & ~trig_r;
    assign abort_act  = I_abort & (state != IDLE);
    assign start      = arm_edge & ~abort_act & ((state == IDLE) | (state == DONE));
    assign win_end    = (win_len != '0) ? (win_cnt == win_len) : (seen_capturing & ~I_capturing);
    assign next_count = O_trig_count + pTRIG_COUNT_WIDTH'(1);
    assign O_state    = state;

`ifdef FE_SEQ_MULTI_TRIG_EN
    logic [pTRIG_COUNT_WIDTH-1:0] num_trig;

    assign last_window = next_count >= num_trig;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            num_trig <= '0;
        else if (start)
            num_trig <= (I_num_triggers == '0) ? pTRIG_COUNT_WIDTH'(1) : I_num_triggers;
    end
`else
    logic unused_num_triggers;

    assign unused_num_triggers = ^I_num_triggers;
    assign last_window         = 1'b1;
`endif

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            arm_r            <= 1'b0;
            trig_r           <= 1'b0;
            primed           <= 1'b0;
            seen_capturing   <= 1'b0;
            delay_cnt        <= '0;
            win_cnt          <= '0;
            win_len          <= '0;
            O_flush          <= 1'b0;
            O_capture_enable <= 1'b0;
            O_armed          <= 1'b0;
            O_done           <= 1'b0;
            O_trig_count     <= '0;
        end else begin
            arm_r  <= I_arm;
            trig_r <= I_trigger;
            primed <= 1'b1;
            if (abort_act) begin
                state            <= IDLE;
                O_flush          <= 1'b0;
                O_capture_enable <= 1'b0;
                O_armed          <= 1'b0;
                O_done           <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE: if (start) begin
                        state        <= FLUSH;
                        O_flush      <= 1'b1;
                        O_done       <= 1'b0;
                        O_trig_count <= '0;
                    end
                    FLUSH: if (I_fifo_empty) begin
                        state   <= ARMED;
                        O_flush <= 1'b0;
                        O_armed <= 1'b1;
                    end
                    ARMED: if (trig_edge) begin
                        O_armed        <= 1'b0;
                        delay_cnt      <= I_trig_delay;
                        win_len        <= I_window_len;
                        win_cnt        <= pWINDOW_WIDTH'(1);
                        seen_capturing <= 1'b0;
                        if (I_trig_delay == '0) begin
                            state            <= CAPTURE;
                            O_capture_enable <= 1'b1;
                        end else begin
                            state <= DELAY;
                        end
                    end
                    DELAY: if (delay_cnt == pDELAY_WIDTH'(1)) begin
                        state            <= CAPTURE;
                        O_capture_enable <= 1'b1;
                        win_len          <= I_window_len;
                        win_cnt          <= pWINDOW_WIDTH'(1);
                        seen_capturing   <= 1'b0;
                    end else begin
                        delay_cnt <= delay_cnt - pDELAY_WIDTH'(1);
                    end
                    CAPTURE: if (win_end) begin
                        O_capture_enable <= 1'b0;
                        O_trig_count     <= next_count;
                        state            <= last_window ? DONE : ARMED;
                        O_done           <= last_window;
                        O_armed          <= ~last_window;
                    end else begin
                        seen_capturing <= seen_capturing | I_capturing;
                        if (win_len != '0)
                            win_cnt <= win_cnt + pWINDOW_WIDTH'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
